ws2812_frame_driver: RTL and testbench
======================================

Name: ws2812_frame_driver

Overview:
- Consumer end of the colour-RAM / update handshake: the colour producer fills LED_NUM 24-bit words, pulses update_reqeust and waits for update_done.
- This block reads the RAM sequentially and serialises each word onto a single-wire WS2812-style LED chain (NRZ pulse-width coding).
- It then holds the line low for the latch/reset gap and reports completion on update_done.

Parameters:
- LED_NUM, 16, number of LEDs/words per frame.
- ADDR_BIT, $clog2(LED_NUM)+1, RAM read-address width (matches producer write port).
- RD_LATENCY, 2, CLK cycles from ram_rdaddress change to valid ram_q.
- T0H, 20, high time of a '0' bit in CLK cycles (0.4 us at 50 MHz).
- T1H, 40, high time of a '1' bit in CLK cycles.
- T_BIT, 62, total bit period in CLK cycles.
- RESET_CYCLES, 15000, low latch gap after the last bit (300 us at 50 MHz).

Ports:
- CLK, in, 1, system clock; also the RAM read clock.
- RST_N, in, 1, reset.
- update_reqeust, in, 1, frame request from the producer; rising edge starts a frame.
- update_done, out, 1, high = idle/frame complete; low = frame in progress.
- ram_rdaddress, out, ADDR_BIT, colour RAM read address.
- ram_q, in, 24, colour RAM read data.
- LED_DOUT, out, 1, serial data to the LED chain.
- ST, out, 3, current state (debug).

Behaviour:
- Interface: reset RST_N, asynchronous, active-low; clock CLK.
- Reset values: update_done=0, LED_DOUT=0, ram_rdaddress=0, ST=IDLE, req_d=0, all counters/shift registers=0. Reset mid-frame aborts immediately with the line low; no partial-frame recovery.
- Static constraints: 1<=T0H<T1H<T_BIT; RD_LATENCY<=24*T_BIT-2.
- Edge detect: req_d <= update_reqeust every cycle; start = update_reqeust & ~req_d. A request already high at reset release counts as an edge.
- Edges outside IDLE are ignored and not queued. A request held high across a whole frame does not retrigger.
- IDLE: update_done=1 (registered, so it rises the first cycle after reset), LED_DOUT=0.
  - On start (sampling edge k): update_done=0, ram_rdaddress=0, go FETCH0 at k+1.
- FETCH0: wait RD_LATENCY cycles, then go LOAD.
- LOAD (one cycle): shift <= ram_q, pix_cnt=0, bit_cnt=23, go BIT.
- First LED_DOUT rise occurs at edge k+RD_LATENCY+2.
- BIT: per-bit counter c runs 0..T_BIT-1. LED_DOUT=1 while c<(shift[23] ? T1H : T0H), else 0.
  - At c=T_BIT-1: shift left 1 and bit_cnt-1.
  - After bit 0: if pixel<LED_NUM-1, shift <= next_word, pix+1 with no gap cycle; otherwise go GAP.
  - Bits are transmitted MSB first, exactly as stored. The producer owns the GRB/RGB ordering.
- Prefetch: at c=0 of bit 23 of pixel i (i<LED_NUM-1), ram_rdaddress <= i+1; RD_LATENCY cycles later, next_word <= ram_q.
  - Consecutive pixels are back-to-back: every bit period is exactly T_BIT.
- GAP: LED_DOUT=0 for RESET_CYCLES cycles, then go DONE.
- DONE: ram_rdaddress <= 0, update_done <= 1, go IDLE.
- Frame latency: from the sampling edge to update_done high = RD_LATENCY + 2 + LED_NUM*24*T_BIT + RESET_CYCLES cycles.
- update_done falls exactly 1 cycle after the sampling edge. This satisfies a producer that holds the request for 11 cycles and then waits for done.
- The RAM may be rewritten during GAP; frame data is fully consumed before GAP.

Test Plan:
Bench params for all scenarios: LED_NUM=2, RD_LATENCY=2, T0H=2, T1H=4, T_BIT=6, RESET_CYCLES=10.
- Reset/idle: hold RST_N low, release -> update_done=0 in reset, 1 on the first clock after; LED_DOUT=0; ram_rdaddress=0.
- Single frame: RAM={0xA50000,0x0000FF}, 1-cycle request at edge k.
  - update_done=0 at k+1; first rise at k+4.
  - High-pulse widths 4,2,4,2,2,4,2,4 then 2x16 for word 0; 2x16 then 4x8 for word 1.
  - update_done=1 at k+302.
- Back-to-back timing: measure every rising-to-rising interval across the pixel 0->1 boundary -> exactly 6 cycles; ram_rdaddress=1 at the start of bit 23 of pixel 0.
- Request handshake: request held high for 11 cycles, then again for 400 cycles -> one frame each; no retrigger while held.
- Ignored request: extra pulse during BIT or GAP -> no second frame.
- Async reset mid-frame: RST_N low during pixel 1 -> LED_DOUT=0 and update_done=0 immediately; a new request after release gives a full correct frame.

Source files
------------

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver
//
// Reads one frame of LED_NUM 24-bit colour words from a synchronous colour
// RAM and serialises them MSB first onto a single-wire WS2812-style chain
// using NRZ pulse-width coding. After the last bit the line is held low for
// the latch gap, and then completion is reported on update_done.
//
// Ports:
//   CLK            system clock, also the RAM read clock
//   RST_N          asynchronous active-low reset
//   update_reqeust frame request from the producer, rising edge starts a frame
//   update_done    1 = idle / frame complete, 0 = frame in progress
//   ram_rdaddress  colour RAM read address
//   ram_q          colour RAM read data, valid RD_LATENCY cycles after address
//   LED_DOUT       serial data to the LED chain
//   ST             current FSM state (debug)
//
// Operating limits: 1 <= T0H < T1H < T_BIT and RD_LATENCY <= 24*T_BIT-2.
// The second limit guarantees that the prefetched word is captured before
// the last bit of the current pixel ends.

module ws2812_frame_driver #(
    parameter int LED_NUM      = 16,
    parameter int ADDR_BIT     = $clog2(LED_NUM) + 1,
    parameter int RD_LATENCY   = 2,
    parameter int T0H          = 20,
    parameter int T1H          = 40,
    parameter int T_BIT        = 62,
    parameter int RESET_CYCLES = 15000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                update_reqeust,
    output logic                update_done,
    output logic [ADDR_BIT-1:0] ram_rdaddress,
    input  logic [23:0]         ram_q,
    output logic                LED_DOUT,
    output logic [2:0]          ST
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        LOAD   = 3'd2,
        BIT    = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } state_t;

    // One shared wait counter covers both the first-word fetch and the gap.
    localparam int WAIT_MAX = (RESET_CYCLES > RD_LATENCY) ? RESET_CYCLES : RD_LATENCY;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam int TMR_W    = $clog2(T_BIT + 1);
    localparam int PF_W     = $clog2(RD_LATENCY + 2);

    localparam logic [CNT_W-1:0]    FETCH_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(T_BIT - 1);
    localparam logic [TMR_W-1:0]    T0H_C      = TMR_W'(T0H);
    localparam logic [TMR_W-1:0]    T1H_C      = TMR_W'(T1H);
    localparam logic [ADDR_BIT-1:0] PIX_LAST   = ADDR_BIT'(LED_NUM - 1);
    localparam logic [ADDR_BIT-1:0] ONE_A      = ADDR_BIT'(1);
    localparam logic [ADDR_BIT-1:0] TWO_A      = ADDR_BIT'(2);
    // The RAM output is sampled one edge after it becomes valid, hence +1.
    localparam logic [PF_W-1:0]     PF_START   = PF_W'(RD_LATENCY + 1);

    state_t              state, state_n;
    logic                req_d;
    logic                start_q;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_n;
    logic [TMR_W-1:0]    bit_tmr, bit_tmr_n;
    logic [4:0]          bit_cnt, bit_cnt_n;
    logic [ADDR_BIT-1:0] pix_cnt, pix_cnt_n;
    logic [23:0]         shift_reg, shift_reg_n;
    logic [23:0]         next_word, next_word_n;
    logic [PF_W-1:0]     pf_cnt, pf_cnt_n;
    logic [ADDR_BIT-1:0] rdaddr_n;
    logic                led_n;
    logic                done_n;

    assign ST = state;

    // Request edge detector. The edge is registered into start_q and only
    // honoured while idle, so edges during a frame are dropped rather than
    // queued, and a request held high never produces a second edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_d   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            req_d   <= update_reqeust;
            start_q <= update_reqeust & ~req_d & (state == IDLE);
        end
    end

    // State and datapath registers. LED_DOUT and update_done are registered
    // from the next-state values so the line never glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bit_tmr       <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            shift_reg     <= '0;
            next_word     <= '0;
            pf_cnt        <= '0;
            ram_rdaddress <= '0;
            LED_DOUT      <= 1'b0;
            update_done   <= 1'b0;
        end else begin
            state         <= state_n;
            wait_cnt      <= wait_cnt_n;
            bit_tmr       <= bit_tmr_n;
            bit_cnt       <= bit_cnt_n;
            pix_cnt       <= pix_cnt_n;
            shift_reg     <= shift_reg_n;
            next_word     <= next_word_n;
            pf_cnt        <= pf_cnt_n;
            ram_rdaddress <= rdaddr_n;
            LED_DOUT      <= led_n;
            update_done   <= done_n;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        bit_tmr_n   = bit_tmr;
        bit_cnt_n   = bit_cnt;
        pix_cnt_n   = pix_cnt;
        shift_reg_n = shift_reg;
        next_word_n = next_word;
        pf_cnt_n    = pf_cnt;
        rdaddr_n    = ram_rdaddress;

        // Prefetch pipeline: runs alongside bit transmission and captures
        // the next pixel's word once the RAM output has settled.
        if (pf_cnt != '0) begin
            pf_cnt_n = pf_cnt - 1'b1;
            if (pf_cnt == PF_W'(1)) begin
                next_word_n = ram_q;
            end
        end

        case (state)
            IDLE: begin
                if (start_q) begin
                    state_n    = (RD_LATENCY == 0) ? LOAD : FETCH0;
                    rdaddr_n   = '0;
                    wait_cnt_n = '0;
                end
            end

            FETCH0: begin
                if (wait_cnt == FETCH_LAST) begin
                    state_n = LOAD;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            LOAD: begin
                shift_reg_n = ram_q;
                pix_cnt_n   = '0;
                bit_cnt_n   = 5'd23;
                bit_tmr_n   = '0;
                state_n     = BIT;
                // The address for pixel 1 is presented as bit 23 of pixel 0
                // starts, leaving a whole pixel time for the read.
                if (LED_NUM > 1) begin
                    rdaddr_n = ONE_A;
                    pf_cnt_n = PF_START;
                end
            end

            BIT: begin
                if (bit_tmr == TMR_LAST) begin
                    bit_tmr_n = '0;
                    if (bit_cnt != 5'd0) begin
                        shift_reg_n = {shift_reg[22:0], 1'b0};
                        bit_cnt_n   = bit_cnt - 5'd1;
                    end else if (pix_cnt != PIX_LAST) begin
                        // Next pixel starts immediately, no gap cycle.
                        shift_reg_n = next_word;
                        pix_cnt_n   = pix_cnt + ONE_A;
                        bit_cnt_n   = 5'd23;
                        if ((pix_cnt + ONE_A) != PIX_LAST) begin
                            rdaddr_n = pix_cnt + TWO_A;
                            pf_cnt_n = PF_START;
                        end
                    end else begin
                        state_n    = GAP;
                        wait_cnt_n = '0;
                    end
                end else begin
                    bit_tmr_n = bit_tmr + 1'b1;
                end
            end

            GAP: begin
                if (wait_cnt == GAP_LAST) begin
                    state_n = DONE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            DONE: begin
                rdaddr_n = '0;
                state_n  = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        led_n  = (state_n == BIT) &&
                 (bit_tmr_n < (shift_reg_n[23] ? T1H_C : T0H_C));
        done_n = (state_n == IDLE) || (state_n == DONE);
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Testbench for ws2812_frame_driver with a small two-LED frame.
// Stimulus tasks push expected pulses and handshake edges into queues; a
// monitor on the falling clock edge pops and compares them as the DUT
// produces LED pulses and update_done transitions.

module tb_ws2812_frame_driver;

    localparam int LED_NUM      = 2;
    localparam int ADDR_BIT     = 2;
    localparam int RD_LATENCY   = 2;
    localparam int T0H          = 2;
    localparam int T1H          = 4;
    localparam int T_BIT        = 6;
    localparam int RESET_CYCLES = 10;
    localparam int FIRST_RISE   = RD_LATENCY + 2;
    localparam int FRAME_CYC    = RD_LATENCY + 2 + LED_NUM * 24 * T_BIT + RESET_CYCLES;

    typedef struct {
        int width;
        bit first;
        int rise_cyc;
    } pulse_t;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                update_reqeust = 1'b0;
    logic                update_done;
    logic [ADDR_BIT-1:0] ram_rdaddress;
    logic [23:0]         ram_q;
    logic                LED_DOUT;
    logic [2:0]          ST;

    logic [23:0] mem [0:3];
    logic [23:0] q1;

    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    pulse_t exp_pulse [$];
    int     exp_fall [$];
    int     exp_done [$];

    ws2812_frame_driver #(
        .LED_NUM(LED_NUM),
        .ADDR_BIT(ADDR_BIT),
        .RD_LATENCY(RD_LATENCY),
        .T0H(T0H),
        .T1H(T1H),
        .T_BIT(T_BIT),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .update_reqeust(update_reqeust),
        .update_done(update_done),
        .ram_rdaddress(ram_rdaddress),
        .ram_q(ram_q),
        .LED_DOUT(LED_DOUT),
        .ST(ST)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Two-stage registered colour RAM read port.
    always @(posedge CLK) begin
        q1    <= mem[ram_rdaddress];
        ram_q <= q1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Issue a request held high for hold cycles and queue everything the
    // frame should produce. k is the first edge that sees the request high.
    task automatic applyStimulus(input int hold, output int k);
        pulse_t p;
        @(negedge CLK);
        k = cyc + 1;
        exp_fall.push_back(k + 1);
        exp_done.push_back(k + FRAME_CYC);
        for (int w = 0; w < LED_NUM; w++) begin
            for (int b = 23; b >= 0; b--) begin
                p.width    = mem[w][b] ? T1H : T0H;
                p.first    = (w == 0) && (b == 23);
                p.rise_cyc = k + FIRST_RISE;
                exp_pulse.push_back(p);
            end
        end
        update_reqeust = 1'b1;
        repeat (hold) @(negedge CLK);
        update_reqeust = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    // Wait for the monitor to consume every queued expectation, then check
    // the idle outputs.
    task automatic waitIdle(input string name, input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            left = exp_pulse.size() + exp_fall.size() + exp_done.size();
            if (left == 0) break;
            @(negedge CLK);
        end
        left = exp_pulse.size() + exp_fall.size() + exp_done.size();
        checkOutput({name, "_pending"}, left, 0);
        exp_pulse.delete();
        exp_fall.delete();
        exp_done.delete();
        repeat (3) @(negedge CLK);
        checkOutput({name, "_idle_done"}, update_done, 1);
        checkOutput({name, "_idle_led"}, LED_DOUT, 0);
        checkOutput({name, "_idle_addr"}, ram_rdaddress, 0);
    endtask

    // Monitor: measures LED pulses and update_done edges on the falling edge.
    int  last_rise;
    bit  rise_valid;
    bit  led_prev;
    bit  done_prev;
    always @(negedge CLK) begin
        pulse_t e;
        if (!RST_N) begin
            led_prev   = 1'b0;
            done_prev  = 1'b0;
            rise_valid = 1'b0;
        end else begin
            if (LED_DOUT && !led_prev) begin
                checkOutput("pulse_expected", int'(exp_pulse.size() > 0), 1);
                if (exp_pulse.size() > 0) begin
                    e = exp_pulse[0];
                    if (e.first) begin
                        checkOutput("first_rise_cycle", cyc, e.rise_cyc);
                        checkOutput("rdaddr_bit23_pix0", ram_rdaddress, 1);
                    end else if (rise_valid) begin
                        checkOutput("bit_period", cyc - last_rise, T_BIT);
                    end
                end
                last_rise  = cyc;
                rise_valid = 1'b1;
            end
            if (!LED_DOUT && led_prev && exp_pulse.size() > 0) begin
                e = exp_pulse.pop_front();
                checkOutput("pulse_width", cyc - last_rise, e.width);
            end
            if (!update_done && done_prev) begin
                checkOutput("frame_start_expected", int'(exp_fall.size() > 0), 1);
                if (exp_fall.size() > 0) checkOutput("done_fall_cycle", cyc, exp_fall.pop_front());
            end
            if (update_done && !done_prev) begin
                checkOutput("done_rise_expected", int'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) checkOutput("done_rise_cycle", cyc, exp_done.pop_front());
            end
            led_prev  = LED_DOUT;
            done_prev = update_done;
        end
    end

    initial begin
        int k;
        mem[0] = 24'hA50000;
        mem[1] = 24'h0000FF;
        mem[2] = 24'h000000;
        mem[3] = 24'h000000;

        // Reset and idle.
        repeat (3) @(negedge CLK);
        checkOutput("reset_done", update_done, 0);
        checkOutput("reset_led", LED_DOUT, 0);
        checkOutput("reset_addr", ram_rdaddress, 0);
        checkOutput("reset_state", ST, 0);
        exp_done.push_back(cyc + 1);
        RST_N = 1'b1;
        waitIdle("reset_release", 10);

        // Single frame, one-cycle request.
        $display("[TB] single frame");
        applyStimulus(1, k);
        waitIdle("single_frame", FRAME_CYC + 20);

        // Producer-style 11-cycle request, then a request held for 400.
        $display("[TB] request handshake");
        mem[0] = 24'h123456;
        mem[1] = 24'h800001;
        applyStimulus(11, k);
        waitIdle("hold11", FRAME_CYC + 20);
        applyStimulus(400, k);
        waitIdle("hold400", 50);
        repeat (20) @(negedge CLK);

        // Extra request pulses during BIT and GAP are ignored.
        $display("[TB] ignored requests");
        applyStimulus(1, k);
        waitUntil(k + 49);
        update_reqeust = 1'b1;
        @(negedge CLK);
        update_reqeust = 1'b0;
        waitUntil(k + FRAME_CYC - 8);
        update_reqeust = 1'b1;
        @(negedge CLK);
        update_reqeust = 1'b0;
        waitIdle("ignored_req", FRAME_CYC + 20);
        repeat (20) @(negedge CLK);

        // Asynchronous reset during pixel 1, then a full frame afterwards.
        $display("[TB] reset mid-frame");
        applyStimulus(1, k);
        waitUntil(k + FIRST_RISE + 24 * T_BIT + 1);
        for (int i = 0; i < 30 && !LED_DOUT; i++) @(negedge CLK);
        checkOutput("abort_led_before", LED_DOUT, 1);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("abort_led", LED_DOUT, 0);
        checkOutput("abort_done", update_done, 0);
        checkOutput("abort_addr", ram_rdaddress, 0);
        exp_pulse.delete();
        exp_fall.delete();
        exp_done.delete();
        repeat (3) @(negedge CLK);
        exp_done.push_back(cyc + 1);
        RST_N = 1'b1;
        waitIdle("abort_release", 10);
        mem[0] = 24'hF0F0F0;
        mem[1] = 24'h0F0F0F;
        applyStimulus(1, k);
        waitIdle("after_abort", FRAME_CYC + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
